systolic_sequencer: RTL and testbench
=====================================

Name: systolic_sequencer

Overview:
- Sub-controller for systolic mode. Sequences one weight preload, then four feature-load strides.
- Drives per-stride feature base addresses.
- Schedules result capture into the c11/c12/c21/c22 registers after the fixed systolic pipeline latency.
- The top-level Controller uses a single start/done handshake with it instead of stepping the systolic datapath itself.

Parameters:
- FEAT_BASE, 6'd9, memory address of stride-0 feature window
- ROW_STEP, 6'd3, address offset added for strides 2 and 3 (bit1 of stride index)
- COL_STEP, 6'd1, address offset added for strides 1 and 3 (bit0 of stride index)
- DRAIN_CYC, 3, systolic pipeline latency (clock edges) from feature_Loader_done to result valid; legal range 1..7

Ports:
- clk, input, 1, system clock, rising edge
- rst, input, 1, asynchronous active-low reset
- start, input, 1, begin systolic sequence (level, sampled in IDLE only)
- weight_Preloader_done, input, 1, weight preload complete
- feature_Loader_done, input, 1, current stride feature load complete
- Weight_Preloader_en, output, 1, enable weight preloader
- Feature_Loader_en, output, 1, enable feature loader
- systolic_mode, output, 1, 0 = weight preload, 1 = feature load/compute
- systolic_mode_feature_baseaddr, output, 6, base address for current stride
- c_reg_sel, output, 2, result register select (0 = c11, 1 = c12, 2 = c21, 3 = c22)
- c_reg_en, output, 1, one-cycle write strobe for the selected c register
- stride_idx, output, 2, current stride number
- busy, output, 1, high in every state except IDLE
- systolic_done, output, 1, one-cycle pulse when all four results are captured

Behaviour:
- Reset (rst = 0, async): state IDLE. All outputs 0; systolic_mode_feature_baseaddr = FEAT_BASE; delay line cleared. Reset mid-sequence aborts immediately, and no pending capture survives it.
- All outputs are registered, Moore style; the delay line is registered.
- States: IDLE, WLOAD, FLOAD, GAP, DRAIN, FIN.
- IDLE: start = 1 at an edge -> WLOAD. Weight_Preloader_en = 1 and busy = 1 from that edge.
- WLOAD:
  - Weight_Preloader_en = 1, systolic_mode = 0.
  - weight_Preloader_done = 1 at an edge -> FLOAD, stride_idx = 0.
- FLOAD:
  - Feature_Loader_en = 1, systolic_mode = 1.
  - baseaddr = FEAT_BASE + (stride_idx[1] ? ROW_STEP : 0) + (stride_idx[0] ? COL_STEP : 0), truncated mod 64.
  - feature_Loader_done = 1 at an edge: push {valid = 1, sel = stride_idx} into the delay line.
  - Then -> GAP if stride_idx < 3, else -> DRAIN.
- GAP:
  - Exactly one cycle; Feature_Loader_en = 0, which guarantees the loader sees a fresh enable.
  - stride_idx increments and baseaddr updates in the same cycle; next state FLOAD.
- DRAIN: Feature_Loader_en = 0, systolic_mode stays 1. Waits until the delay line holds no valid entry, then -> FIN.
- FIN: systolic_done = 1 for one cycle, busy drops, next state IDLE. systolic_mode returns to 0 in IDLE.
- Delay line:
  - DRAIN_CYC stages, shifting every cycle in all states.
  - An entry pushed at edge E0 appears at the tail after edge E0 + DRAIN_CYC - 1.
  - c_reg_en = tail valid; c_reg_sel = tail sel, held at its last value when not valid.
  - Entries from consecutive strides never collide: at most one push per cycle.
  - Overlap is allowed: a capture may occur while the next stride is already loading.
- Ignored inputs:
  - start while busy.
  - weight_Preloader_done outside WLOAD.
  - feature_Loader_done outside FLOAD (including GAP and DRAIN).
- Simultaneous done and start in IDLE: only start acts.
- A done held high for several cycles counts once per FLOAD visit, because GAP consumes one cycle and FLOAD re-samples afterwards. A level held through GAP therefore advances the next stride on the first FLOAD edge; this is legal.
- Total cycles from start to systolic_done are data-dependent. The minimum with immediate dones and DRAIN_CYC = 3 is 1 (WLOAD) + 4 FLOAD + 3 GAP + drain + 1 FIN.

Test Plan:
- Reset/idle: rst = 0 mid-FLOAD at stride 2 -> all outputs 0 and baseaddr = 9 immediately (asynchronously); after rst = 1 the state is IDLE and no c_reg_en fires afterward.
- Nominal flow:
  - Stimulus: start pulse; weight done after 3 cycles; feature done after 3 cycles for each stride.
  - Required: baseaddr 9, 10, 12, 13 on strides 0..3.
  - Required: c_reg_en pulses with c_reg_sel 0, 1, 2, 3, each 3 cycles after its done.
  - Required: a single systolic_done pulse after the sel = 3 capture; busy = 0 afterward.
- Back-to-back dones:
  - Stimulus: feature_Loader_done tied to 1 from the first FLOAD.
  - Required: strides advance every 2 cycles; 4 distinct c_reg_en pulses, sel 0..3, in order with no loss.
  - Required: systolic_done only after the last one.
- Spurious inputs: weight done during FLOAD, feature done during WLOAD/GAP/DRAIN, and start while busy -> no state change, no extra c_reg_en.
- Parameter sweep: DRAIN_CYC = 1 and 7 -> capture latency 1 and 7 edges respectively; systolic_done waits for the last capture.
- Wrap: FEAT_BASE = 62, ROW_STEP = 3, COL_STEP = 1 -> baseaddr 62, 63, 1, 2.

Source files
------------

// File: rtl/systolic_sequencer.sv
// systolic_sequencer
//   Sub-controller for systolic mode. Runs one weight preload, then four
//   feature-load strides, and drives each stride's feature window base
//   address. Every accepted stride is tagged into a fixed-latency delay line
//   that mirrors the systolic pipeline, so result capture into c11/c12/c21/c22
//   is strobed exactly DRAIN_CYC edges after that stride's load completes.
//
// Ports
//   clk                            in   system clock, rising edge
//   rst                            in   asynchronous reset, active low
//   start                          in   begin a sequence (sampled in IDLE only)
//   weight_Preloader_done          in   weight preload complete
//   feature_Loader_done            in   current stride feature load complete
//   Weight_Preloader_en            out  weight preloader enable
//   Feature_Loader_en              out  feature loader enable
//   systolic_mode                  out  0 = weight preload, 1 = feature/compute
//   systolic_mode_feature_baseaddr out  [5:0] feature base address of stride
//   c_reg_sel                      out  [1:0] result register (c11,c12,c21,c22)
//   c_reg_en                       out  one-cycle write strobe for c_reg_sel
//   stride_idx                     out  [1:0] current stride number
//   busy                           out  high whenever not IDLE
//   systolic_done                  out  one-cycle pulse after the last capture
module systolic_sequencer #(
    parameter logic [5:0] FEAT_BASE = 6'd9,
    parameter logic [5:0] ROW_STEP  = 6'd3,
    parameter logic [5:0] COL_STEP  = 6'd1,
    parameter int         DRAIN_CYC = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       weight_Preloader_done,
    input  logic       feature_Loader_done,
    output logic       Weight_Preloader_en,
    output logic       Feature_Loader_en,
    output logic       systolic_mode,
    output logic [5:0] systolic_mode_feature_baseaddr,
    output logic [1:0] c_reg_sel,
    output logic       c_reg_en,
    output logic [1:0] stride_idx,
    output logic       busy,
    output logic       systolic_done
);

    localparam int SW = 2 * DRAIN_CYC;

    typedef enum logic [2:0] {
        IDLE,
        WLOAD,
        FLOAD,
        GAP,
        DRAIN,
        FIN
    } state_t;

    state_t state;

    // Stride base address: bit1 of the stride steps a row, bit0 a column.
    // The 6-bit sum wraps naturally at 64.
    function automatic logic [5:0] stride_addr(input logic [1:0] s);
        logic [5:0] a;
        a = FEAT_BASE;
        if (s[1]) a = a + ROW_STEP;
        if (s[0]) a = a + COL_STEP;
        return a;
    endfunction

    // Stage p0: a stride whose feature load completes this cycle.
    logic                 vld_p0;
    logic [DRAIN_CYC-1:0] dl_vld;
    logic [DRAIN_CYC-1:0] dl_vld_nxt;
    logic [SW-1:0]        dl_sel;
    logic [SW-1:0]        dl_sel_nxt;

    assign vld_p0 = (state == FLOAD) && feature_Loader_done;

    // Shift toward the tail; the cast drops the entry leaving the tail.
    assign dl_vld_nxt = DRAIN_CYC'({dl_vld, vld_p0});
    assign dl_sel_nxt = SW'({dl_sel, stride_idx});

    // Tail of the delay line: capture strobe.
    assign c_reg_en = dl_vld[DRAIN_CYC-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dl_vld    <= '0;
            dl_sel    <= '0;
            c_reg_sel <= 2'd0;
        end else begin
            dl_vld <= dl_vld_nxt;
            dl_sel <= dl_sel_nxt;
            // Select follows the tail but holds its last value between captures.
            if (dl_vld_nxt[DRAIN_CYC-1]) begin
                c_reg_sel <= dl_sel_nxt[SW-1 -: 2];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                          <= IDLE;
            Weight_Preloader_en            <= 1'b0;
            Feature_Loader_en              <= 1'b0;
            systolic_mode                  <= 1'b0;
            systolic_mode_feature_baseaddr <= FEAT_BASE;
            stride_idx                     <= 2'd0;
            busy                           <= 1'b0;
            systolic_done                  <= 1'b0;
        end else begin
            systolic_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state               <= WLOAD;
                        Weight_Preloader_en <= 1'b1;
                        busy                <= 1'b1;
                        systolic_mode       <= 1'b0;
                    end
                end
                WLOAD: begin
                    if (weight_Preloader_done) begin
                        state                          <= FLOAD;
                        Weight_Preloader_en            <= 1'b0;
                        Feature_Loader_en              <= 1'b1;
                        systolic_mode                  <= 1'b1;
                        stride_idx                     <= 2'd0;
                        systolic_mode_feature_baseaddr <= stride_addr(2'd0);
                    end
                end
                FLOAD: begin
                    if (feature_Loader_done) begin
                        Feature_Loader_en <= 1'b0;
                        if (stride_idx != 2'd3) begin
                            // Next stride's index and address are visible during GAP.
                            state                          <= GAP;
                            stride_idx                     <= stride_idx + 2'd1;
                            systolic_mode_feature_baseaddr <= stride_addr(stride_idx + 2'd1);
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                GAP: begin
                    // One cycle with the enable low so the loader sees a fresh rising enable.
                    state             <= FLOAD;
                    Feature_Loader_en <= 1'b1;
                end
                DRAIN: begin
                    if (dl_vld == '0) begin
                        state         <= FIN;
                        systolic_done <= 1'b1;
                    end
                end
                FIN: begin
                    state                          <= IDLE;
                    busy                           <= 1'b0;
                    systolic_mode                  <= 1'b0;
                    stride_idx                     <= 2'd0;
                    systolic_mode_feature_baseaddr <= FEAT_BASE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_sequencer.sv
// tb_systolic_sequencer
//   Four instances share one set of inputs: DRAIN_CYC = 3, 1 and 7 with the
//   default address map, and DRAIN_CYC = 3 with FEAT_BASE = 62 to exercise
//   address wrap. Each scenario task drives directed stimulus and compares
//   against hand-computed expectations.
module tb_systolic_sequencer;

    localparam int NI = 4;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic wdone;
    logic fdone;

    logic [NI-1:0] w_en;
    logic [NI-1:0] f_en;
    logic [NI-1:0] mode;
    logic [NI-1:0] c_en;
    logic [NI-1:0] busy;
    logic [NI-1:0] sdone;
    logic [5:0]    base [NI];
    logic [1:0]    csel [NI];
    logic [1:0]    sidx [NI];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int         cap_n  [NI];
    int         cap_c  [NI][64];
    logic [1:0] cap_s  [NI][64];
    int         done_n [NI];
    int         done_c [NI];
    int         n_snap [NI];
    int         d_snap [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int         D = (g == 1) ? 1 : (g == 2) ? 7 : 3;
        localparam logic [5:0] B = (g == 3) ? 6'd62 : 6'd9;
        systolic_sequencer #(
            .FEAT_BASE(B),
            .ROW_STEP (6'd3),
            .COL_STEP (6'd1),
            .DRAIN_CYC(D)
        ) u_dut (
            .clk                           (clk),
            .rst                           (rst),
            .start                         (start),
            .weight_Preloader_done         (wdone),
            .feature_Loader_done           (fdone),
            .Weight_Preloader_en           (w_en[g]),
            .Feature_Loader_en             (f_en[g]),
            .systolic_mode                 (mode[g]),
            .systolic_mode_feature_baseaddr(base[g]),
            .c_reg_sel                     (csel[g]),
            .c_reg_en                      (c_en[g]),
            .stride_idx                    (sidx[g]),
            .busy                          (busy[g]),
            .systolic_done                 (sdone[g])
        );
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Event log: capture strobes and done pulses, stamped with the edge count.
    initial begin
        for (int g = 0; g < NI; g++) begin
            cap_n[g]  = 0;
            done_n[g] = 0;
            done_c[g] = 0;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < NI; g++) begin
                if (c_en[g] === 1'b1) begin
                    if (cap_n[g] < 64) begin
                        cap_c[g][cap_n[g]] = cyc;
                        cap_s[g][cap_n[g]] = csel[g];
                    end
                    cap_n[g] = cap_n[g] + 1;
                end
                if (sdone[g] === 1'b1) begin
                    done_c[g] = cyc;
                    done_n[g] = done_n[g] + 1;
                end
            end
        end
    end

    function automatic int dc(input int g);
        case (g)
            1:       return 1;
            2:       return 7;
            default: return 3;
        endcase
    endfunction

    function automatic logic [5:0] exp_base(input int g, input int s);
        logic [5:0] t [4];
        if (g == 3) t = '{6'd62, 6'd63, 6'd1, 6'd2};
        else        t = '{6'd9, 6'd10, 6'd12, 6'd13};
        return t[s];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        for (int g = 0; g < NI; g++) begin
            n_snap[g] = cap_n[g];
            d_snap[g] = done_n[g];
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            ok = 1'b1;
            for (int g = 0; g < NI; g++) begin
                if (done_n[g] == d_snap[g]) ok = 1'b0;
            end
            if (ok) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; wdone = 1'b0; fdone = 1'b0;
        step(); step(); step();
        for (int g = 0; g < NI; g++) begin
            total++;
            if ({w_en[g], f_en[g], mode[g], c_en[g], busy[g], sdone[g], sidx[g], csel[g]} !== 10'b0) begin
                bad++;
                $display("FAIL reset_outputs inst=%0d got=%b required=0",
                         g, {w_en[g], f_en[g], mode[g], c_en[g], busy[g], sdone[g], sidx[g], csel[g]});
            end
            total++;
            if (base[g] !== exp_base(g, 0)) begin
                bad++;
                $display("FAIL reset_base inst=%0d got=%0d required=%0d", g, base[g], exp_base(g, 0));
            end
        end
        rst = 1'b1;
        step(); step();
        total++;
        if (busy !== 4'h0 || w_en !== 4'h0 || c_en !== 4'h0) begin
            bad++;
            $display("FAIL idle_after_reset busy=%b w_en=%b c_en=%b required all 0", busy, w_en, c_en);
        end
    endtask

    task automatic test_nominal();
        int pe [4];
        bit ok;
        snap();
        start = 1'b1; step(); start = 1'b0;
        total++;
        if (w_en !== 4'hF || busy !== 4'hF || mode !== 4'h0 || f_en !== 4'h0) begin
            bad++;
            $display("FAIL nom_wload w_en=%b busy=%b mode=%b f_en=%b required F,F,0,0", w_en, busy, mode, f_en);
        end
        step(); step(); wdone = 1'b1; step(); wdone = 1'b0;
        for (int s = 0; s < 4; s++) begin
            for (int g = 0; g < NI; g++) begin
                total++;
                if (f_en[g] !== 1'b1 || mode[g] !== 1'b1 || w_en[g] !== 1'b0 ||
                    sidx[g] !== s[1:0] || base[g] !== exp_base(g, s)) begin
                    bad++;
                    $display("FAIL nom_fload inst=%0d stride=%0d got en=%b mode=%b idx=%0d base=%0d required 1,1,%0d,%0d",
                             g, s, f_en[g], mode[g], sidx[g], base[g], s, exp_base(g, s));
                end
            end
            step(); step(); fdone = 1'b1; step(); fdone = 1'b0;
            pe[s] = cyc;
            if (s < 3) begin
                total++;
                if (f_en !== 4'h0 || busy !== 4'hF) begin
                    bad++;
                    $display("FAIL nom_gap f_en=%b busy=%b required 0,F", f_en, busy);
                end
                step();
            end
        end
        total++;
        if (f_en !== 4'h0 || mode !== 4'hF || busy !== 4'hF) begin
            bad++;
            $display("FAIL nom_drain f_en=%b mode=%b busy=%b required 0,F,F", f_en, mode, busy);
        end
        wait_done(40, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL nom_done_timeout got=no_done required=done within 40 cycles");
        end
        for (int g = 0; g < NI; g++) begin
            total++;
            if (cap_n[g] - n_snap[g] !== 4) begin
                bad++;
                $display("FAIL nom_capture_count inst=%0d got=%0d required=4", g, cap_n[g] - n_snap[g]);
            end else begin
                for (int s = 0; s < 4; s++) begin
                    total++;
                    if (cap_s[g][n_snap[g]+s] !== s[1:0] || cap_c[g][n_snap[g]+s] !== pe[s] + dc(g) - 1) begin
                        bad++;
                        $display("FAIL nom_capture inst=%0d n=%0d got sel=%0d edge=%0d required sel=%0d edge=%0d",
                                 g, s, cap_s[g][n_snap[g]+s], cap_c[g][n_snap[g]+s], s, pe[s] + dc(g) - 1);
                    end
                end
                total++;
                if (done_n[g] - d_snap[g] !== 1 || done_c[g] <= cap_c[g][n_snap[g]+3] ||
                    done_c[g] > cap_c[g][n_snap[g]+3] + 3) begin
                    bad++;
                    $display("FAIL nom_done inst=%0d got pulses=%0d edge=%0d required 1 pulse within 3 edges after %0d",
                             g, done_n[g] - d_snap[g], done_c[g], cap_c[g][n_snap[g]+3]);
                end
            end
        end
        step(); step();
        total++;
        if (busy !== 4'h0 || mode !== 4'h0 || w_en !== 4'h0 || f_en !== 4'h0) begin
            bad++;
            $display("FAIL nom_idle busy=%b mode=%b w_en=%b f_en=%b required all 0", busy, mode, w_en, f_en);
        end
        for (int g = 0; g < NI; g++) begin
            total++;
            if (csel[g] !== 2'd3) begin
                bad++;
                $display("FAIL nom_sel_hold inst=%0d got=%0d required=3", g, csel[g]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int f0;
        bit ok;
        snap();
        start = 1'b1; step(); start = 1'b0;
        wdone = 1'b1; step(); wdone = 1'b0;
        fdone = 1'b1;
        f0 = cyc;
        for (int k = 1; k < 4; k++) begin
            step();
            total++;
            if (f_en !== 4'h0) begin
                bad++;
                $display("FAIL b2b_gap k=%0d f_en=%b required 0", k, f_en);
            end
            step();
            for (int g = 0; g < NI; g++) begin
                total++;
                if (f_en[g] !== 1'b1 || sidx[g] !== k[1:0] || base[g] !== exp_base(g, k)) begin
                    bad++;
                    $display("FAIL b2b_stride inst=%0d k=%0d got en=%b idx=%0d base=%0d required 1,%0d,%0d",
                             g, k, f_en[g], sidx[g], base[g], k, exp_base(g, k));
                end
            end
        end
        wait_done(40, ok);
        fdone = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL b2b_done_timeout got=no_done required=done within 40 cycles");
        end
        for (int g = 0; g < NI; g++) begin
            total++;
            if (cap_n[g] - n_snap[g] !== 4) begin
                bad++;
                $display("FAIL b2b_capture_count inst=%0d got=%0d required=4", g, cap_n[g] - n_snap[g]);
            end else begin
                for (int s = 0; s < 4; s++) begin
                    total++;
                    if (cap_s[g][n_snap[g]+s] !== s[1:0] ||
                        cap_c[g][n_snap[g]+s] !== f0 + 1 + 2 * s + dc(g) - 1) begin
                        bad++;
                        $display("FAIL b2b_capture inst=%0d n=%0d got sel=%0d edge=%0d required sel=%0d edge=%0d",
                                 g, s, cap_s[g][n_snap[g]+s], cap_c[g][n_snap[g]+s], s, f0 + 2 * s + dc(g));
                    end
                end
                total++;
                if (done_n[g] - d_snap[g] !== 1 || done_c[g] <= cap_c[g][n_snap[g]+3]) begin
                    bad++;
                    $display("FAIL b2b_done inst=%0d got pulses=%0d edge=%0d required 1 pulse after %0d",
                             g, done_n[g] - d_snap[g], done_c[g], cap_c[g][n_snap[g]+3]);
                end
            end
        end
        step(); step();
    endtask

    task automatic test_spurious();
        int pe [4];
        bit ok;
        snap();
        // Start together with both dones in IDLE: only start acts.
        start = 1'b1; wdone = 1'b1; fdone = 1'b1; step(); wdone = 1'b0;
        total++;
        if (w_en !== 4'hF || f_en !== 4'h0 || mode !== 4'h0 || busy !== 4'hF) begin
            bad++;
            $display("FAIL spur_idle w_en=%b f_en=%b mode=%b busy=%b required F,0,0,F", w_en, f_en, mode, busy);
        end
        // Feature done and start while in WLOAD.
        step(); start = 1'b0; fdone = 1'b0;
        total++;
        if (w_en !== 4'hF || f_en !== 4'h0) begin
            bad++;
            $display("FAIL spur_wload w_en=%b f_en=%b required F,0", w_en, f_en);
        end
        wdone = 1'b1; step(); wdone = 1'b0;
        // Weight done and start while in FLOAD.
        wdone = 1'b1; start = 1'b1; step(); wdone = 1'b0; start = 1'b0;
        step();
        for (int g = 0; g < NI; g++) begin
            total++;
            if (f_en[g] !== 1'b1 || w_en[g] !== 1'b0 || sidx[g] !== 2'd0 || base[g] !== exp_base(g, 0)) begin
                bad++;
                $display("FAIL spur_fload inst=%0d got en=%b wen=%b idx=%0d base=%0d required 1,0,0,%0d",
                         g, f_en[g], w_en[g], sidx[g], base[g], exp_base(g, 0));
            end
        end
        // Stride 0 done, held through the GAP edge only.
        fdone = 1'b1; step(); pe[0] = cyc;
        step(); fdone = 1'b0;
        step();
        for (int g = 0; g < NI; g++) begin
            total++;
            if (f_en[g] !== 1'b1 || sidx[g] !== 2'd1) begin
                bad++;
                $display("FAIL spur_gap inst=%0d got en=%b idx=%0d required 1,1", g, f_en[g], sidx[g]);
            end
        end
        for (int s = 1; s < 4; s++) begin
            fdone = 1'b1; step(); fdone = 1'b0;
            pe[s] = cyc;
            if (s < 3) step();
        end
        // Feature done and start while draining.
        fdone = 1'b1; start = 1'b1; step(); fdone = 1'b0; start = 1'b0;
        total++;
        if (busy !== 4'hF || f_en !== 4'h0 || w_en !== 4'h0) begin
            bad++;
            $display("FAIL spur_drain busy=%b f_en=%b w_en=%b required F,0,0", busy, f_en, w_en);
        end
        wait_done(40, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL spur_done_timeout got=no_done required=done within 40 cycles");
        end
        step(); step(); step();
        for (int g = 0; g < NI; g++) begin
            total++;
            if (cap_n[g] - n_snap[g] !== 4 || done_n[g] - d_snap[g] !== 1) begin
                bad++;
                $display("FAIL spur_counts inst=%0d got caps=%0d dones=%0d required 4,1",
                         g, cap_n[g] - n_snap[g], done_n[g] - d_snap[g]);
            end else begin
                for (int s = 0; s < 4; s++) begin
                    total++;
                    if (cap_s[g][n_snap[g]+s] !== s[1:0] || cap_c[g][n_snap[g]+s] !== pe[s] + dc(g) - 1) begin
                        bad++;
                        $display("FAIL spur_capture inst=%0d n=%0d got sel=%0d edge=%0d required sel=%0d edge=%0d",
                                 g, s, cap_s[g][n_snap[g]+s], cap_c[g][n_snap[g]+s], s, pe[s] + dc(g) - 1);
                    end
                end
            end
        end
        total++;
        if (busy !== 4'h0) begin
            bad++;
            $display("FAIL spur_idle_end busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        start = 1'b1; step(); start = 1'b0;
        wdone = 1'b1; step(); wdone = 1'b0;
        fdone = 1'b1; step(); fdone = 1'b0;
        step();
        fdone = 1'b1; step(); fdone = 1'b0;
        step();
        snap();
        for (int g = 0; g < NI; g++) begin
            total++;
            if (sidx[g] !== 2'd2 || f_en[g] !== 1'b1 || base[g] !== exp_base(g, 2)) begin
                bad++;
                $display("FAIL rmid_setup inst=%0d got idx=%0d en=%b base=%0d required 2,1,%0d",
                         g, sidx[g], f_en[g], base[g], exp_base(g, 2));
            end
        end
        #2;
        rst = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) begin
            total++;
            if ({w_en[g], f_en[g], mode[g], c_en[g], busy[g], sdone[g], sidx[g], csel[g]} !== 10'b0 ||
                base[g] !== exp_base(g, 0)) begin
                bad++;
                $display("FAIL rmid_async inst=%0d got=%b base=%0d required 0 base=%0d",
                         g, {w_en[g], f_en[g], mode[g], c_en[g], busy[g], sdone[g], sidx[g], csel[g]},
                         base[g], exp_base(g, 0));
            end
        end
        step(); step();
        rst = 1'b1;
        for (int i = 0; i < 12; i++) step();
        for (int g = 0; g < NI; g++) begin
            total++;
            if (cap_n[g] !== n_snap[g] || done_n[g] !== d_snap[g] || busy[g] !== 1'b0) begin
                bad++;
                $display("FAIL rmid_after inst=%0d got extra caps=%0d dones=%0d busy=%b required 0,0,0",
                         g, cap_n[g] - n_snap[g], done_n[g] - d_snap[g], busy[g]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_back_to_back();
        test_spurious();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
